inst_mem_ws: RTL and testbench
==============================

# inst_mem_ws

Parametrised instruction memory with a configurable wait-state count, a one-entry fetch buffer and a run-time program-load port. It sits between the openmips core's fetch interface (ce/addr/inst) and the pipeline control block. Misses stall the core through `stall_req` for a fixed, parameter-defined penalty. It replaces the fixed single-cycle instruction ROM in the minimal SoC top and allows slow-memory timing to be modelled.

## Interface
- `DATA_W`, 32: instruction width in bits.
- `ADDR_W`, 32: byte-address width from the core.
- `DEPTH`, 1024: memory depth in words; power of two, 2..65536; `IDX_W = log2(DEPTH)`.
- `WAIT`, 1: extra wait states per miss, 0..15.
- `CNT_W`, 32: width of the miss counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ce`  in  1  fetch enable from the core.
- `addr`  in  ADDR_W  fetch byte address.
- `inst`  out  DATA_W  fetched instruction; 0 (nop) when not valid.
- `inst_valid`  out  1  `inst` is valid this cycle.
- `stall_req`  out  1  stall request to pipeline control.
- `misalign`  out  1  `ce`=1 and `addr[1:0]`≠0.
- `ld_en`  in  1  program-load write strobe.
- `ld_addr`  in  IDX_W  load word index.
- `ld_data`  in  DATA_W  load data.
- `miss_cnt`  out  CNT_W  saturating count of misses since reset.

## Operation
- Word index = `addr[IDX_W+1:2]`. Address bits above the index are ignored, so addresses wrap modulo `DEPTH*4`.
- Fetch buffer: registers `buf_data`, `buf_idx`, `buf_v`.
- Hit = `ce` & `buf_v` & (`buf_idx` == index) & !`misalign`.
- `inst` = `buf_data` on a hit, else 0. `inst_valid` = hit.
- `misalign`: `inst`=0, `inst_valid`=0, `stall_req`=0. No fill occurs; the cycle is not counted as a miss.
- `ce`=0: `inst`=0, `inst_valid`=0, `stall_req`=0. If the FSM is in BUSY it returns to IDLE and the fill is aborted.
- FSM states IDLE and BUSY; 4-bit counter `cnt`; captured index `req_idx`.
  - IDLE, `ce`=1, miss, aligned: `stall_req`=1 (combinational). At the clock edge, go to BUSY with `req_idx`←index, `cnt`←WAIT, and `miss_cnt`+1, saturating at all-ones.
  - BUSY: `stall_req`=1. If the current index ≠ `req_idx`, restart: `req_idx`←index, `cnt`←WAIT, `miss_cnt`+1, stay in BUSY.
  - BUSY with `cnt`=0: fill `buf_data`←mem[`req_idx`], `buf_idx`←`req_idx`, `buf_v`←1, then go to IDLE.
  - BUSY with `cnt`>0: `cnt`−1.
- Load port: when `ld_en`=1, mem[`ld_addr`]←`ld_data` at the edge. This is independent of the FSM.
  - If `buf_v` and `buf_idx`==`ld_addr`: `buf_v`←0 (invalidate).
  - Load and fill to the same index in the same edge: the fill captures `ld_data` (write-first) and `buf_v` stays 1.
- Memory contents at power-up are undefined; `rst` does not clear the array.

## Timing
- Reset: state IDLE, `buf_v`=0, `buf_data`=0, `cnt`=0, `miss_cnt`=0. While `rst`=1, `stall_req`, `inst_valid`, `inst` and `misalign` are forced to 0.
- Reset mid-BUSY aborts the fill immediately (asynchronous).
- Miss penalty: `stall_req` is high for exactly WAIT+2 consecutive cycles.
  - Miss cycle T.
  - BUSY cycles T+1..T+WAIT+1.
  - Hit at T+WAIT+2.
- Hit latency: 0 cycles (combinational from `addr`/`ce`); no stall.
- A load to the buffered index at edge E turns the next fetch of that index, from E+1 onward, into a miss.
- `miss_cnt` updates one edge after the miss cycle.

## Test plan
- Reset, load mem[0..3]=0x34010001..04, WAIT=1. `ce`=1, `addr`=0 → `stall_req` high 3 cycles, then `inst`=0x34010001 with `inst_valid`=1; `miss_cnt`=1.
- Hold `addr`=0 for 5 cycles after the fill → `inst_valid`=1 every cycle, `stall_req`=0, `miss_cnt` unchanged. Step to `addr`=4 → new 3-cycle stall, `inst`=0x34010002.
- WAIT=0 and WAIT=15 builds, single miss → stall lengths of 2 and 17 cycles respectively.
- Buffer holds index 2, `ld_en` writes `ld_addr`=2 with 0xDEADBEEF → next fetch of `addr`=8 misses and returns 0xDEADBEEF.
- `addr`=0x2 → `misalign`=1, `inst`=0, no stall. `addr`=DEPTH*4 → returns mem[0] (wrap).
- Assert `rst` in the 2nd BUSY cycle, then release with `ce`=1, `addr`=0 → all outputs 0 during reset, full miss penalty restarts, `miss_cnt` restarts at 1.

Source files
------------

// File: rtl/inst_mem_ws.sv
// Instruction memory with a one-word fetch buffer and a fixed per-miss penalty of WAIT+2 stall cycles.
// Hits are combinational with zero latency. A miss holds stall_req high until the buffer is refilled.
module inst_mem_ws #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 1,
  parameter int CNT_W  = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              stall_req,
  output logic              misalign,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   buf_idx;
  logic [DATA_W-1:0]  buf_data;
  logic               buf_v;
  logic [DATA_W-1:0]  fill_data;
  logic               mis, hit;
  logic               start, fill, dec;
  logic               unused_addr_hi;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign idx            = addr[IDX_W+1:2];
  assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W+2];
  assign mis            = ce && (addr[1:0] != 2'b00);
  assign hit            = ce && !mis && buf_v && (buf_idx == idx);

  // A load landing on the word being filled this edge wins over the stale array value.
  assign fill_data = (ld_en && (ld_addr == req_idx)) ? ld_data : mem[req_idx];

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    fill       = 1'b0;
    dec        = 1'b0;
    inst       = '0;
    inst_valid = 1'b0;
    stall_req  = 1'b0;
    misalign   = 1'b0;
    if (!rst) begin
      misalign   = mis;
      inst_valid = hit;
      inst       = hit ? buf_data : '0;
      stall_req  = ce && !mis && !hit;
    end
    case (state)
      IDLE: begin
        if (ce && !mis && !hit) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A hit here means the core went back to the buffered word, so the fill is dropped.
        if (!ce || mis || hit) begin
          state_nxt = IDLE;
        end else if (idx != req_idx) begin
          start = 1'b1;
        end else if (cnt == 4'd0) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      req_idx  <= '0;
      buf_v    <= 1'b0;
      buf_idx  <= '0;
      buf_data <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        req_idx <= idx;
        cnt     <= 4'(WAIT);
        if (miss_cnt != {CNT_W{1'b1}}) begin
          miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end else if (dec) begin
        cnt <= cnt - 4'd1;
      end
      if (fill) begin
        buf_data <= fill_data;
        buf_idx  <= req_idx;
        buf_v    <= 1'b1;
      end else if (ld_en && buf_v && (buf_idx == ld_addr)) begin
        buf_v <= 1'b0;
      end
    end
  end

  // The array has no reset so program contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_inst_mem_ws.sv
// Bench for inst_mem_ws: three builds (WAIT=1, 0, 15) share one stimulus stream and are
// compared every cycle against a fetch/miss model, plus directed penalty, load, wrap and reset cases.
module tb_inst_mem_ws;

  localparam int N     = 3;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0]      o_inst  [N];
  logic             o_valid [N];
  logic             o_stall [N];
  logic             o_mis   [N];
  logic [CNT_W-1:0] o_miss  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    inst_mem_ws #(
      .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT(wait_of(g)), .CNT_W(CNT_W)
    ) dut (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr),
      .inst(o_inst[g]), .inst_valid(o_valid[g]), .stall_req(o_stall[g]),
      .misalign(o_mis[g]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .miss_cnt(o_miss[g])
    );
  end

  always #5 clk = ~clk;

  logic [31:0] m_mem   [DEPTH];
  bit          m_bv    [N];
  int          m_bidx  [N];
  logic [31:0] m_bdata [N];
  bit          m_pend  [N];
  int          m_req   [N];
  int          m_age   [N];
  int          m_miss  [N];

  logic [31:0] s_inst  [N];
  bit          s_valid [N];
  bit          s_stall [N];
  bit          s_mis   [N];
  int          s_miss  [N];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare at the falling edge, then advance the model across the rising edge.
  task automatic step();
    int idx;
    bit mis, hit, fill;
    @(negedge clk);
    idx = int'(addr[5:2]);
    mis = ce && (addr[1:0] != 2'b00);
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        m_bv[k] = 0; m_bdata[k] = '0; m_pend[k] = 0; m_miss[k] = 0;
      end
      hit = !rst && ce && !mis && m_bv[k] && (m_bidx[k] == idx);
      s_inst[k]  = o_inst[k];
      s_valid[k] = o_valid[k];
      s_stall[k] = o_stall[k];
      s_mis[k]   = o_mis[k];
      s_miss[k]  = int'(o_miss[k]);
      check($sformatf("inst[%0d]", k), o_inst[k], hit ? m_bdata[k] : 32'h0);
      check($sformatf("valid[%0d]", k), o_valid[k], hit);
      check($sformatf("stall[%0d]", k), o_stall[k], !rst && ce && !mis && !hit);
      check($sformatf("misalign[%0d]", k), o_mis[k], !rst && mis);
      check($sformatf("miss_cnt[%0d]", k), o_miss[k], m_miss[k]);
    end
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        hit  = ce && !mis && m_bv[k] && (m_bidx[k] == idx);
        fill = 0;
        if (!ce || mis || hit) begin
          m_pend[k] = 0;
        end else if (!m_pend[k] || (m_req[k] != idx)) begin
          m_pend[k] = 1; m_req[k] = idx; m_age[k] = 0;
          if (m_miss[k] < SAT) m_miss[k]++;
        end else begin
          m_age[k]++;
          if (m_age[k] == wait_of(k) + 1) fill = 1;
        end
        if (fill) begin
          m_bdata[k] = (ld_en && (int'(ld_addr) == m_req[k])) ? ld_data : m_mem[m_req[k]];
          m_bv[k] = 1; m_bidx[k] = m_req[k]; m_pend[k] = 0;
        end else if (ld_en && m_bv[k] && (m_bidx[k] == int'(ld_addr))) begin
          m_bv[k] = 0;
        end
      end
      if (ld_en) m_mem[ld_addr] = ld_data;
    end
    #1;
  endtask

  // Hold a fetch until every build returns data; check stall length, data and miss count.
  task automatic fetch_measure(input string tag, input logic [31:0] a,
                               input logic [31:0] expv, input int exp_miss);
    int          len  [N];
    bit          seen [N];
    logic [31:0] got  [N];
    int          gmis [N];
    int          n;
    bit          all;
    ce = 1'b1; addr = a;
    for (int k = 0; k < N; k++) begin
      len[k] = 0; seen[k] = 0; got[k] = '0; gmis[k] = 0;
    end
    n = 0; all = 0;
    while (!all && n < 40) begin
      step();
      n++;
      all = 1;
      for (int k = 0; k < N; k++) begin
        if (!seen[k]) begin
          if (s_valid[k]) begin
            seen[k] = 1; got[k] = s_inst[k]; gmis[k] = s_miss[k];
          end else if (s_stall[k]) begin
            len[k]++;
          end
        end
        if (!seen[k]) all = 0;
      end
    end
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_done[%0d]", tag, k), seen[k], 1);
      check($sformatf("%s_stall_len[%0d]", tag, k), len[k], wait_of(k) + 2);
      check($sformatf("%s_inst[%0d]", tag, k), got[k], expv);
      check($sformatf("%s_miss[%0d]", tag, k), gmis[k], exp_miss);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int k = 0; k < N; k++) begin
      m_bv[k] = 0; m_bidx[k] = 0; m_bdata[k] = '0; m_pend[k] = 0;
      m_req[k] = 0; m_age[k] = 0; m_miss[k] = 0;
    end
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = 4'(i);
      ld_data = (i < 4) ? 32'h3401_0001 + 32'(i) : $urandom;
      step();
    end
    ld_en = 1'b0;

    fetch_measure("first", 32'h0, 32'h3401_0001, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      for (int k = 0; k < N; k++) begin
        check($sformatf("hold_valid[%0d]", k), s_valid[k], 1);
        check($sformatf("hold_stall[%0d]", k), s_stall[k], 0);
        check($sformatf("hold_miss[%0d]", k), s_miss[k], 1);
      end
    end
    fetch_measure("next", 32'h4, 32'h3401_0002, 2);
    fetch_measure("idx2", 32'h8, 32'h3401_0003, 3);

    ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'hDEAD_BEEF;
    step();
    ld_en = 1'b0;
    fetch_measure("reload", 32'h8, 32'hDEAD_BEEF, 4);

    ce = 1'b1; addr = 32'h2;
    step();
    for (int k = 0; k < N; k++) begin
      check($sformatf("mis_flag[%0d]", k), s_mis[k], 1);
      check($sformatf("mis_inst[%0d]", k), s_inst[k], 0);
      check($sformatf("mis_stall[%0d]", k), s_stall[k], 0);
    end
    fetch_measure("wrap", 32'(DEPTH * 4), 32'h3401_0001, 5);

    ce = 1'b1; addr = 32'h4;
    step();
    step();
    rst = 1'b1; addr = 32'h2;
    step();
    addr = 32'h0;
    step();
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_stall[%0d]", k), s_stall[k], 0);
      check($sformatf("rst_valid[%0d]", k), s_valid[k], 0);
      check($sformatf("rst_inst[%0d]", k), s_inst[k], 0);
      check($sformatf("rst_miss[%0d]", k), s_miss[k], 0);
    end
    rst = 1'b0;
    fetch_measure("after_rst", 32'h0, 32'h3401_0001, 1);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 25) begin
        addr = 32'($urandom_range(0, 5)) * 4;
        if ($urandom_range(0, 99) < 5)  addr[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 99) < 20) addr[31:6] = 26'($urandom);
      end
      ce      = ($urandom_range(0, 99) < 90);
      ld_en   = ($urandom_range(0, 99) < 8);
      ld_addr = 4'($urandom_range(0, 5));
      ld_data = $urandom;
      rst     = ($urandom_range(0, 999) < 5);
      step();
    end
    rst = 1'b0; ld_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
